dht11_read_scheduler: RTL and testbench

DHT11_READ_SCHEDULER -- requirements
Module: dht11_read_scheduler

---
 rtl/dht11_read_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_dht11_read_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_read_scheduler.sv
// dht11_read_scheduler
//   Schedules read sequences on a DHT11 reader. A sequence starts after a
//   periodic interval or earlier on request. Each attempt is checked for
//   timeout and checksum. A failed attempt is retried after a minimum gap.
//   The final result is published over a valid/ready handshake.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   PERIOD_MS  nominal interval between read sequences
//   GAP_MS     minimum spacing between two sensor_start pulses
//   TIMEOUT_MS maximum wait from sensor_start to sensor_done
//   MAX_RETRY  retries after a failed attempt (0 = no retries)
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   enable          periodic scheduling allowed
//   force_req       one-cycle request for an early read
//   sensor_start    one-cycle start pulse to the reader
//   sensor_done     one-cycle pulse, sensor_frame valid
//   sensor_frame    {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   result_valid/result_ready  result handshake
//   result_hum, result_temp    integer bytes of the last captured frame
//   result_status   00 ok, 01 checksum fail, 10 timeout
//   err_count       saturating count of failed attempts
module dht11_read_scheduler #(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned GAP_MS     = 1000,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        force_req,
    output logic        sensor_start,
    input  logic        sensor_done,
    input  logic [39:0] sensor_frame,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [7:0]  result_hum,
    output logic [7:0]  result_temp,
    output logic [1:0]  result_status,
    output logic [7:0]  err_count
);

    // Cycle counts are computed in 64 bits: ms * Hz overflows 32 bits at
    // the default settings.
    localparam longint unsigned PERIOD_L = (64'(PERIOD_MS)  * 64'(CLK_FREQ)) / 64'd1000;
    localparam longint unsigned GAP_L    = (64'(GAP_MS)     * 64'(CLK_FREQ)) / 64'd1000;
    localparam longint unsigned TO_L     = (64'(TIMEOUT_MS) * 64'(CLK_FREQ)) / 64'd1000;

    localparam int unsigned PERIOD_CYC = 32'(PERIOD_L);
    localparam int unsigned GAP_CYC    = 32'(GAP_L);
    localparam int unsigned TO_CYC     = 32'(TO_L);

    localparam int unsigned PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC + 1) : 1;
    localparam int unsigned GW = (GAP_CYC    > 1) ? $clog2(GAP_CYC + 1)    : 1;
    localparam int unsigned TW = (TO_CYC     > 1) ? $clog2(TO_CYC + 1)     : 1;
    localparam int unsigned RW = (MAX_RETRY  > 1) ? $clog2(MAX_RETRY + 1)  : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PERIOD,
        START,
        WAIT_DONE,
        CHECK,
        BACKOFF,
        PUBLISH
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [PW-1:0] period_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retry_cnt;
    logic          force_pending;
    logic          timed_out;
    logic [39:0]   frame_reg;

    logic          period_done;
    logic          gap_ok;
    logic          timeout_hit;
    logic [7:0]    csum_calc;
    logic          csum_ok;
    logic          attempt_fail;
    logic          retry_left;
    logic [1:0]    check_status;

    assign period_done  = (period_cnt == PW'(PERIOD_CYC - 1));
    assign gap_ok       = (gap_cnt >= GW'(GAP_CYC));
    // The last waiting cycle is the timeout cycle; a coinciding done is lost.
    assign timeout_hit  = (state == WAIT_DONE) && (to_cnt == TW'(TO_CYC - 1));
    assign csum_calc    = frame_reg[39:32] + frame_reg[31:24] + frame_reg[23:16] + frame_reg[15:8];
    assign csum_ok      = (csum_calc == frame_reg[7:0]);
    assign attempt_fail = timed_out || !csum_ok;
    assign retry_left   = (retry_cnt < RW'(MAX_RETRY));
    assign check_status = timed_out ? 2'b10 : (csum_ok ? 2'b00 : 2'b01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        sensor_start = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = WAIT_PERIOD;
                end else if (force_pending && gap_ok) begin
                    next_state = START;
                end
            end
            WAIT_PERIOD: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (period_done || (force_pending && gap_ok)) begin
                    next_state = START;
                end
            end
            START: begin
                sensor_start = 1'b1;
                next_state   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (timeout_hit || sensor_done) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (attempt_fail && retry_left) begin
                    next_state = BACKOFF;
                end else begin
                    next_state = PUBLISH;
                end
            end
            BACKOFF: begin
                if (gap_ok) begin
                    next_state = START;
                end
            end
            PUBLISH: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    next_state = enable ? WAIT_PERIOD : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt    <= '0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
            retry_cnt     <= '0;
            force_pending <= 1'b0;
            timed_out     <= 1'b0;
            frame_reg     <= '0;
            result_hum    <= '0;
            result_temp   <= '0;
            result_status <= '0;
            err_count     <= '0;
        end else begin
            // Cleared whenever outside WAIT_PERIOD, so every entry starts at 0.
            if (state == WAIT_PERIOD) begin
                period_cnt <= period_cnt + PW'(1);
            end else begin
                period_cnt <= '0;
            end

            // Counts cycles since the last start, holding once the gap is met.
            if (sensor_start) begin
                gap_cnt <= GW'(1);
            end else if (!gap_ok) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (sensor_start) begin
                force_pending <= 1'b0;
            end else if (force_req) begin
                force_pending <= 1'b1;
            end

            case (state)
                START: begin
                    to_cnt    <= '0;
                    timed_out <= 1'b0;
                    // A new sequence forgets frames from earlier sequences.
                    if (retry_cnt == '0) begin
                        frame_reg <= '0;
                    end
                end
                WAIT_DONE: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (timeout_hit) begin
                        timed_out <= 1'b1;
                    end else if (sensor_done) begin
                        frame_reg <= sensor_frame;
                    end
                end
                CHECK: begin
                    if (attempt_fail && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (attempt_fail && retry_left) begin
                        retry_cnt <= retry_cnt + RW'(1);
                    end else begin
                        result_hum    <= frame_reg[39:32];
                        result_temp   <= frame_reg[23:16];
                        result_status <= check_status;
                        retry_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// tb_dht11_read_scheduler
//   Directed bench for dht11_read_scheduler with small cycle counts:
//   period 20, gap 10, timeout 5 cycles, two retries.
module tb_dht11_read_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        force_req;
    logic        sensor_start;
    logic        sensor_done;
    logic [39:0] sensor_frame;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  result_hum;
    logic [7:0]  result_temp;
    logic [1:0]  result_status;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_starts = 0;
    int n_pubs   = 0;
    logic valid_q = 1'b0;

    localparam logic [39:0] FRAME_A   = 40'h2D00170044;
    localparam logic [39:0] FRAME_BAD = 40'h2D00170045;
    localparam logic [39:0] FRAME_B   = 40'h1A05200342;

    dht11_read_scheduler #(
        .CLK_FREQ  (1000),
        .PERIOD_MS (20),
        .GAP_MS    (10),
        .TIMEOUT_MS(5),
        .MAX_RETRY (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .force_req    (force_req),
        .sensor_start (sensor_start),
        .sensor_done  (sensor_done),
        .sensor_frame (sensor_frame),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_hum   (result_hum),
        .result_temp  (result_temp),
        .result_status(result_status),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sensor_start) n_starts <= n_starts + 1;
        if (result_valid && !valid_q) n_pubs <= n_pubs + 1;
        valid_q <= result_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        enable       = 1'b0;
        force_req    = 1'b0;
        sensor_done  = 1'b0;
        result_ready = 1'b0;
        sensor_frame = '0;
        idle(2);
        reset_n = 1'b1;
    endtask

    // Returns at the negedge of the cycle where sensor_start is high.
    task automatic wait_start(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sensor_start) return;
        end
        $display("FAIL wait_start: no sensor_start within %0d cycles", max_cyc);
        n_tests++;
        n_fail++;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (result_valid) return;
        end
        $display("FAIL wait_valid: no result_valid within %0d cycles", max_cyc);
        n_tests++;
        n_fail++;
    endtask

    task automatic pulse_done(input logic [39:0] frame);
        sensor_frame = frame;
        sensor_done  = 1'b1;
        idle(1);
        sensor_done  = 1'b0;
    endtask

    initial begin
        int ce, s1, s2, s3, st0, p0;
        logic [7:0] h0, t0;
        logic [1:0] q0;

        reset_n      = 1'b0;
        enable       = 1'b0;
        force_req    = 1'b0;
        sensor_done  = 1'b0;
        result_ready = 1'b0;
        sensor_frame = '0;

        // Reset values and a good read.
        do_reset();
        chk("rst_start",  sensor_start,  0);
        chk("rst_valid",  result_valid,  0);
        chk("rst_hum",    result_hum,    0);
        chk("rst_temp",   result_temp,   0);
        chk("rst_status", result_status, 0);
        chk("rst_err",    err_count,     0);
        ce = cyc;
        enable = 1'b1;
        wait_start(40);
        s1 = cyc;
        chk("ok_start_cycle", s1 - ce, 21);
        idle(1);
        chk("ok_start_one_cycle", sensor_start, 0);
        idle(2);
        pulse_done(FRAME_A);
        wait_valid(10);
        chk("ok_pub_latency", cyc - s1, 5);
        chk("ok_hum",    result_hum,    8'h2D);
        chk("ok_temp",   result_temp,   8'h17);
        chk("ok_status", result_status, 2'b00);
        chk("ok_err",    err_count,     0);
        enable = 1'b0;
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;
        chk("ok_valid_drop", result_valid, 0);

        // Checksum failure on every attempt.
        do_reset();
        enable = 1'b1;
        st0 = n_starts;
        p0  = n_pubs;
        wait_start(40);
        s1 = cyc;
        idle(3);
        pulse_done(FRAME_BAD);
        wait_start(30);
        s2 = cyc;
        idle(3);
        pulse_done(FRAME_BAD);
        wait_start(30);
        s3 = cyc;
        idle(3);
        pulse_done(FRAME_BAD);
        chk("cs_gap12", (s2 - s1) >= 10, 1);
        chk("cs_gap23", (s3 - s2) >= 10, 1);
        wait_valid(20);
        chk("cs_status", result_status, 2'b01);
        chk("cs_hum",    result_hum,    8'h2D);
        chk("cs_temp",   result_temp,   8'h17);
        chk("cs_err",    err_count,     3);
        enable = 1'b0;
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;
        idle(40);
        chk("cs_starts", n_starts - st0, 3);
        chk("cs_pubs",   n_pubs - p0,    1);

        // No answer; a done on the timeout cycle of attempt 2 is ignored.
        do_reset();
        enable = 1'b1;
        wait_start(40);
        s1 = cyc;
        wait_start(30);
        s2 = cyc;
        chk("to_retry_spacing", s2 - s1, 11);
        idle(5);
        pulse_done(FRAME_A);
        wait_start(30);
        s3 = cyc;
        wait_valid(20);
        chk("to_pub_latency", cyc - s3, 7);
        chk("to_status", result_status, 2'b10);
        chk("to_hum",    result_hum,    0);
        chk("to_temp",   result_temp,   0);
        chk("to_err",    err_count,     3);
        enable = 1'b0;
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;

        // Early request honoured only once the gap since the last start is met.
        do_reset();
        result_ready = 1'b1;
        enable = 1'b1;
        wait_start(40);
        s1 = cyc;
        idle(1);
        pulse_done(FRAME_A);
        idle(4);
        force_req = 1'b1;
        idle(1);
        force_req = 1'b0;
        wait_start(30);
        s2 = cyc;
        chk("force_gap_start", s2 - s1, 11);

        // Early request while disabled: exactly one sequence.
        do_reset();
        ce = cyc;
        force_req = 1'b1;
        idle(1);
        force_req = 1'b0;
        wait_start(30);
        s1 = cyc;
        chk("fdis_start", s1 - ce, 11);
        idle(1);
        pulse_done(FRAME_B);
        result_ready = 1'b1;
        st0 = n_starts;
        p0  = n_pubs;
        idle(40);
        chk("fdis_no_restart", n_starts - st0, 0);
        chk("fdis_pubs",       n_pubs - p0,    1);
        chk("fdis_hum",        result_hum,     8'h1A);

        // Last accepted done cycle, then a long stall on result_ready.
        do_reset();
        enable = 1'b1;
        wait_start(40);
        s1 = cyc;
        idle(4);
        pulse_done(FRAME_B);
        wait_valid(10);
        chk("st_pub_latency", cyc - s1, 6);
        chk("st_status", result_status, 2'b00);
        h0 = result_hum;
        t0 = result_temp;
        q0 = result_status;
        chk("st_hum",  h0, 8'h1A);
        chk("st_temp", t0, 8'h20);
        for (int i = 0; i < 50; i++) begin
            idle(1);
            chk("st_valid_held", result_valid, 1);
            chk("st_no_start",   sensor_start, 0);
        end
        chk("st_hum_stable",    result_hum,    h0);
        chk("st_temp_stable",   result_temp,   t0);
        chk("st_status_stable", result_status, q0);
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;
        chk("st_valid_drop", result_valid, 0);

        // Reset during WAIT_DONE, then a late done.
        wait_start(30);
        idle(2);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("mr_hum",    result_hum,    0);
        chk("mr_temp",   result_temp,   0);
        chk("mr_valid",  result_valid,  0);
        chk("mr_status", result_status, 0);
        chk("mr_start",  sensor_start,  0);
        @(negedge clk);
        reset_n = 1'b1;
        st0 = n_starts;
        p0  = n_pubs;
        pulse_done(FRAME_A);
        idle(30);
        chk("mr_no_pub",   n_pubs - p0,    0);
        chk("mr_no_start", n_starts - st0, 0);
        chk("mr_hum_after",    result_hum,    0);
        chk("mr_status_after", result_status, 0);
        chk("mr_err_after",    err_count,     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
